// File: rtl/reg1_display.sv
// Four-digit multiplexed seven-segment driver for the CPU register-1 value.
// A sequential double-dabble converts the value to BCD when it or the mode changes.
module reg1_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] VALUE,
    input  logic       MODE,
    output logic [3:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       BUSY
);
    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    val_q, val_d;
    logic          mode_q, mode_d;
    logic [11:0]   bcd_q, bcd_d, bcd_adj;
    logic [7:0]    bin_q, bin_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    dig0_q, dig0_d, dig1_q, dig1_d, dig2_q, dig2_d;
    logic          show1_q, show1_d, show2_q, show2_d;
    logic          busy_q, busy_d;
    logic [RW-1:0] ref_q, ref_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'h0: enc = 7'b1000000;
            4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;
            4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;
            4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;
            4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b0000011;
            4'hC: enc = 7'b1000110;
            4'hD: enc = 7'b0100001;
            4'hE: enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        mode_d  = mode_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        dig2_d  = dig2_q;
        show1_d = show1_q;
        show2_d = show2_q;
        case (state_q)
            IDLE: begin
                if (VALUE != val_q || MODE != mode_q) begin
                    val_d   = VALUE;
                    mode_d  = MODE;
                    bcd_d   = '0;
                    bin_d   = VALUE;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7)
                    state_d = LOAD;
            end
            LOAD: begin
                if (mode_q) begin
                    dig0_d  = bcd_q[3:0];
                    dig1_d  = bcd_q[7:4];
                    dig2_d  = bcd_q[11:8];
                    show2_d = !BLANK_LZ || (bcd_q[11:8] != 4'd0);
                    show1_d = show2_d || (bcd_q[7:4] != 4'd0);
                end else begin
                    dig0_d  = val_q[3:0];
                    dig1_d  = val_q[7:4];
                    dig2_d  = 4'd0;
                    show1_d = 1'b1;
                    show2_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Anode and segments are computed from the same index so they switch together.
    always_comb begin
        ref_d = (ref_q == REF_MAX) ? '0 : ref_q + RW'(1);
        idx_d = (ref_q == REF_MAX) ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_q);
        case (idx_q)
            2'd0:    seg_d = enc(dig0_q);
            2'd1:    seg_d = show1_q ? enc(dig1_q) : 7'h7F;
            2'd2:    seg_d = show2_q ? enc(dig2_q) : 7'h7F;
            default: seg_d = 7'h7F;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            val_q   <= '0;
            mode_q  <= 1'b0;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            dig0_q  <= '0;
            dig1_q  <= '0;
            dig2_q  <= '0;
            show1_q <= 1'b0;
            show2_q <= 1'b0;
            busy_q  <= 1'b0;
            ref_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            show1_q <= show1_d;
            show2_q <= show2_d;
            busy_q  <= busy_d;
            ref_q   <= ref_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign AN   = an_q;
    assign SEG  = seg_q;
    assign DP   = 1'b1;
    assign BUSY = busy_q;
endmodule

// File: tb/tb_reg1_display.sv
// Directed bench for reg1_display: reset, conversion latency, digit scan and blanking.
module tb_reg1_display;
    logic       CLK;
    logic       RST_N;
    logic [7:0] VALUE;
    logic       MODE;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0010000,
                           SA = 7'b0001000, SF = 7'b0001110, SB = 7'h7F;

    reg1_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .MODE(MODE),
        .AN(AN), .SEG(SEG), .DP(DP), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Wait for the anode of digit idx to be lit, then compare its segments.
    task automatic check_digit(input string tag, input int idx, input logic [6:0] exp);
        logic [3:0] an_exp;
        bit found;
        an_exp = ~(4'b0001 << idx);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge CLK);
            if (AN == an_exp) found = 1'b1;
        end
        if (found) chk(tag, {25'd0, SEG}, {25'd0, exp});
        else       chk({tag, "_anode"}, {28'd0, AN}, {28'd0, an_exp});
    endtask

    // Count sampled cycles with BUSY high until it falls again (bounded).
    task automatic run_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (BUSY) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic apply(input string tag, input logic [7:0] v, input logic m);
        int n;
        @(negedge CLK);
        VALUE = v;
        MODE  = m;
        run_busy(n);
        chk({tag, "_busy"}, n, 9);
    endtask

    initial begin
        int n, r1, r2;
        logic b [1:24];
        RST_N = 1'b1;
        VALUE = 8'd0;
        MODE  = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_an", {28'd0, AN}, 32'hF);
        chk("rst_seg", {25'd0, SEG}, 32'h7F);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_dp", {31'd0, DP}, 32'd1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rel_an", {28'd0, AN}, 32'hE);
        chk("rel_seg", {25'd0, SEG}, {25'd0, S0});
        chk("rel_busy", {31'd0, BUSY}, 32'd0);
        check_digit("rel_d1", 1, SB);
        check_digit("rel_d2", 2, SB);
        check_digit("rel_d3", 3, SB);

        apply("d255", 8'd255, 1'b1);
        check_digit("d255_d2", 2, S2);
        check_digit("d255_d1", 1, S5);
        check_digit("d255_d0", 0, S5);
        check_digit("d255_d3", 3, SB);

        apply("hAF", 8'hAF, 1'b0);
        check_digit("hAF_d1", 1, SA);
        check_digit("hAF_d0", 0, SF);
        check_digit("hAF_d2", 2, SB);
        check_digit("hAF_d3", 3, SB);

        apply("d7", 8'd7, 1'b1);
        check_digit("d7_d2", 2, SB);
        check_digit("d7_d1", 1, SB);
        check_digit("d7_d0", 0, S7);

        apply("d105", 8'd105, 1'b1);
        check_digit("d105_d2", 2, S1);
        check_digit("d105_d1", 1, S0);
        check_digit("d105_d0", 0, S5);

        apply("d0", 8'd0, 1'b1);
        check_digit("d0_d0", 0, S0);
        check_digit("d0_d1", 1, SB);
        check_digit("d0_d2", 2, SB);

        // Value changes while the first conversion is still shifting.
        @(negedge CLK);
        VALUE = 8'd12;
        for (int i = 1; i <= 24; i++) begin
            @(negedge CLK);
            b[i] = BUSY;
            if (i == 3) VALUE = 8'd200;
        end
        r1 = 0;
        for (int i = 1; i <= 24 && b[i]; i++) r1++;
        r2 = 0;
        for (int i = 11; i <= 24 && b[i]; i++) r2++;
        chk("mid_run1", r1, 9);
        chk("mid_gap", {31'd0, b[10]}, 32'd0);
        chk("mid_run2", r2, 9);
        check_digit("mid_d2", 2, S2);
        check_digit("mid_d1", 1, S0);
        check_digit("mid_d0", 0, S0);

        // Reset lands in the middle of the shift phase.
        @(negedge CLK);
        VALUE = 8'd99;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("rmid_an", {28'd0, AN}, 32'hF);
        chk("rmid_seg", {25'd0, SEG}, 32'h7F);
        chk("rmid_busy", {31'd0, BUSY}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rmid_busy_rise", {31'd0, BUSY}, 32'd1);
        run_busy(n);
        chk("rmid_busy_rest", n, 8);
        check_digit("rmid_d0", 0, S9);
        check_digit("rmid_d1", 1, S9);
        check_digit("rmid_d2", 2, SB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
